wb_arbiter_2m1s: RTL and testbench

- Arbitrates the CPU's instruction (wbi) and data (wbd) Wishbone master ports onto a single Wishbone classic slave port, e.g. a unified memory or the bus fabric.
- Sits directly downstream of cpu_assembled; the CPU bench instantiates it between the CPU and the memory model.
- Round-robin fairness, one transaction per grant, and a bus-timeout counter that returns err to the requesting master when the slave never responds.

---
 rtl/wb_arb_pkg.sv | 18 +
 rtl/wb_timeout_cnt.sv | 32 +++
 rtl/wb_arbiter_2m1s.sv | 156 +++++++++++++++
 tb/tb_wb_arbiter_2m1s.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    // One-hot grant encodings; bit0 = m0 (instruction), bit1 = m1 (data)
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Per-transaction wait counter; flags the cycle in which the slave has run out of time.
module wb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic done,
    output logic expire
);

    localparam int unsigned     CntW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] LastCnt = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);
    localparam bit              Enabled = (TIMEOUT != 0);

    logic [CntW-1:0] r_cnt;

    // Count waiting cycles; held at zero while idle and saturating instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (en && !done && (r_cnt != MaxCnt)) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    // A completing ack/err in the final cycle wins over the timeout
    assign expire = Enabled && en && !done && (r_cnt == LastCnt);

endmodule

// File: rtl/wb_arbiter_2m1s.sv
// Round-robin arbiter joining the CPU instruction and data Wishbone masters onto one
// classic slave port, with a per-transaction bus timeout that returns err to the owner.
module wb_arbiter_2m1s
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned SEL_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    // m0: instruction master
    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [SEL_W-1:0]  m0_sel,
    input  logic [DATA_W-1:0] m0_wdat,
    output logic [DATA_W-1:0] m0_rdat,
    output logic              m0_ack,
    output logic              m0_err,
    // m1: data master
    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [SEL_W-1:0]  m1_sel,
    input  logic [DATA_W-1:0] m1_wdat,
    output logic [DATA_W-1:0] m1_rdat,
    output logic              m1_ack,
    output logic              m1_err,
    // shared slave port
    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_adr,
    output logic [SEL_W-1:0]  s_sel,
    output logic [DATA_W-1:0] s_wdat,
    input  logic [DATA_W-1:0] s_rdat,
    input  logic              s_ack,
    input  logic              s_err,
    output logic [1:0]        grant
);

    arb_state_e r_state;
    logic [1:0] r_grant;
    logic       r_last;     // owner of the most recent grant: 0 = m0, 1 = m1

    logic w_req0;
    logic w_req1;
    logic w_own0;
    logic w_own1;
    logic w_owner_cyc;
    logic w_done;
    logic w_expire;

    assign w_req0 = m0_cyc & m0_stb;
    assign w_req1 = m1_cyc & m1_stb;

    // Ownership is masked during reset so nothing leaks out in the reset cycle
    assign w_own0      = (r_state == GNT0) & ~rst;
    assign w_own1      = (r_state == GNT1) & ~rst;
    assign w_owner_cyc = (w_own0 & m0_cyc) | (w_own1 & m1_cyc);
    assign w_done      = s_ack | s_err;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (r_state == IDLE),
        .en     (w_owner_cyc),
        .done   (w_done),
        .expire (w_expire)
    );

    // Arbitration FSM: one transaction per grant, always returning through IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= GNT_NONE;
            r_last  <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req0 && (!w_req1 || r_last)) begin
                        r_state <= GNT0;
                        r_grant <= GNT_M0;
                    end else if (w_req1) begin
                        r_state <= GNT1;
                        r_grant <= GNT_M1;
                    end
                end
                GNT0: begin
                    if (!m0_cyc || w_done || w_expire) begin
                        r_state <= IDLE;
                        r_grant <= GNT_NONE;
                        r_last  <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!m1_cyc || w_done || w_expire) begin
                        r_state <= IDLE;
                        r_grant <= GNT_NONE;
                        r_last  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= GNT_NONE;
                end
            endcase
        end
    end

    assign grant = r_grant;

    // Read data goes to both masters; only the owner ever sees ack/err
    assign m0_rdat = s_rdat;
    assign m1_rdat = s_rdat;

    // Steer the owner onto the slave port; a timeout kills the strobe in its final cycle
    always_comb begin
        s_cyc  = 1'b0;
        s_stb  = 1'b0;
        s_we   = 1'b0;
        s_adr  = '0;
        s_sel  = '0;
        s_wdat = '0;
        m0_ack = 1'b0;
        m0_err = 1'b0;
        m1_ack = 1'b0;
        m1_err = 1'b0;
        if (w_own0) begin
            s_cyc  = m0_cyc & ~w_expire;
            s_stb  = m0_stb & ~w_expire;
            s_we   = m0_we;
            s_adr  = m0_adr;
            s_sel  = m0_sel;
            s_wdat = m0_wdat;
            m0_ack = s_ack;
            m0_err = s_err | w_expire;
        end else if (w_own1) begin
            s_cyc  = m1_cyc & ~w_expire;
            s_stb  = m1_stb & ~w_expire;
            s_we   = m1_we;
            s_adr  = m1_adr;
            s_sel  = m1_sel;
            s_wdat = m1_wdat;
            m1_ack = s_ack;
            m1_err = s_err | w_expire;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m1s.sv
// Bench for wb_arbiter_2m1s: directed vector table, hand-written corner sequences and a
// randomized run, all checked every cycle against a transaction-level reference model.
module tb_wb_arbiter_2m1s;

    localparam int TO = 4;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic        a0;
        logic        e0;
        logic        a1;
        logic        e1;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } obs_t;

    // in  = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err}
    // exp = {grant[1:0], s_cyc, m0_ack, m0_err, m1_ack, m1_err}
    typedef struct packed {
        logic [5:0] in;
        logic [6:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mc [2];
    logic        ms [2];
    logic        mw [2];
    logic [31:0] ma [2];
    logic [3:0]  msl[2];
    logic [31:0] mwd[2];
    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [3:0]  s_sel;
    logic        s_ack, s_err;
    logic [1:0]  grant;

    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;
    obs_t exp_o;

    // Reference model: who owns the port, who won last, how long the owner has waited
    int own;
    int prev;
    int waited;

    always #5 clk = ~clk;

    wb_arbiter_2m1s #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m0_cyc  (mc[0]),
        .m0_stb  (ms[0]),
        .m0_we   (mw[0]),
        .m0_adr  (ma[0]),
        .m0_sel  (msl[0]),
        .m0_wdat (mwd[0]),
        .m0_rdat (m0_rdat),
        .m0_ack  (m0_ack),
        .m0_err  (m0_err),
        .m1_cyc  (mc[1]),
        .m1_stb  (ms[1]),
        .m1_we   (mw[1]),
        .m1_adr  (ma[1]),
        .m1_sel  (msl[1]),
        .m1_wdat (mwd[1]),
        .m1_rdat (m1_rdat),
        .m1_ack  (m1_ack),
        .m1_err  (m1_err),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_adr   (s_adr),
        .s_sel   (s_sel),
        .s_wdat  (s_wdat),
        .s_rdat  (s_rdat),
        .s_ack   (s_ack),
        .s_err   (s_err),
        .grant   (grant)
    );

    function automatic logic model_tmo();
        return (own >= 0) && mc[own] && !(s_ack || s_err) && (waited == TO - 1);
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        logic tmo;
        o     = '0;
        o.rd0 = s_rdat;
        o.rd1 = s_rdat;
        o.gnt = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
        if (!rst && own >= 0) begin
            tmo    = model_tmo();
            o.cyc  = mc[own] && !tmo;
            o.stb  = ms[own] && !tmo;
            o.we   = mw[own];
            o.adr  = ma[own];
            o.sel  = msl[own];
            o.wdat = mwd[own];
            if (own == 0) begin
                o.a0 = s_ack;
                o.e0 = s_err || tmo;
            end else begin
                o.a1 = s_ack;
                o.e1 = s_err || tmo;
            end
        end
        return o;
    endfunction

    task automatic model_step();
        logic r0, r1;
        if (rst) begin
            own    = -1;
            prev   = 1;
            waited = 0;
        end else if (own < 0) begin
            r0     = mc[0] && ms[0];
            r1     = mc[1] && ms[1];
            waited = 0;
            if (r0 && r1)  own = 1 - prev;
            else if (r0)   own = 0;
            else if (r1)   own = 1;
        end else if (s_ack || s_err || !mc[own] || model_tmo()) begin
            prev = own;
            own  = -1;
        end else if (waited < TO) begin
            waited++;
        end
    endtask

    function automatic obs_t dut_obs();
        return {grant, s_cyc, s_stb, s_we, s_adr, s_sel, s_wdat,
                m0_ack, m0_err, m1_ack, m1_err, m0_rdat, m1_rdat};
    endfunction

    task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc_n, got, want);
        end
    endtask

    // Compare the whole DUT output set with the model mid-cycle
    task automatic sample();
        @(negedge clk);
        exp_o = model_out();
        chk("model", 160'(dut_obs()), 160'(exp_o));
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        cyc_n++;
        #1;
    endtask

    task automatic idle_masters();
        for (int x = 0; x < 2; x++) begin
            mc[x] = 1'b0; ms[x] = 1'b0; mw[x] = 1'b0;
            ma[x] = 32'h0000_1000 * (x + 1); msl[x] = 4'hf; mwd[x] = 32'hA5A5_0000 + x;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[32];
        logic done_x;

        tbl = '{
            '{6'b111100, 7'b0000000}, '{6'b111110, 7'b0111000},
            '{6'b111100, 7'b0000000}, '{6'b111110, 7'b1010010},
            '{6'b111100, 7'b0000000}, '{6'b111110, 7'b0111000},
            '{6'b111100, 7'b0000000}, '{6'b111110, 7'b1010010},
            '{6'b111100, 7'b0000000}, '{6'b111110, 7'b0111000},
            '{6'b111100, 7'b0000000}, '{6'b111110, 7'b1010010},
            '{6'b000000, 7'b0000000}, '{6'b001100, 7'b0000000},
            '{6'b001100, 7'b1010000}, '{6'b001100, 7'b1010000},
            '{6'b001100, 7'b1010000}, '{6'b001100, 7'b1000001},
            '{6'b001100, 7'b0000000}, '{6'b001100, 7'b1010000},
            '{6'b001100, 7'b1010000}, '{6'b001100, 7'b1010000},
            '{6'b001110, 7'b1010010}, '{6'b000000, 7'b0000000},
            '{6'b110000, 7'b0000000}, '{6'b110011, 7'b0111100},
            '{6'b110000, 7'b0000000}, '{6'b111100, 7'b0110000},
            '{6'b011100, 7'b0100000}, '{6'b001100, 7'b0000000},
            '{6'b001110, 7'b1010010}, '{6'b000000, 7'b0000000}
        };

        own = -1; prev = 1; waited = 0;
        rst = 1'b1; s_ack = 1'b0; s_err = 1'b0; s_rdat = 32'h0;
        idle_masters();
        advance();
        sample();
        chk("reset_state", 160'({grant, s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err}), 160'(0));
        advance();
        rst = 1'b0;

        // Directed vectors: round robin x6, timeout, ack on the last allowed cycle,
        // ack+err together, master abort with a pending requester
        for (int i = 0; i < 32; i++) begin
            {mc[0], ms[0], mc[1], ms[1], s_ack, s_err} = tbl[i].in;
            s_rdat = 32'h1000_0000 + i;
            sample();
            chk($sformatf("tbl_row%0d", i),
                160'({grant, s_cyc, m0_ack, m0_err, m1_ack, m1_err}), 160'(tbl[i].exp));
            advance();
        end
        idle_masters();
        s_ack = 1'b0; s_err = 1'b0;

        // m0 read with a slave that acks two cycles after the strobe appears
        mc[0] = 1'b1; ms[0] = 1'b1; mw[0] = 1'b0; ma[0] = 32'h0000_0100; msl[0] = 4'hf;
        sample();
        chk("h1_idle_scyc", 160'(s_cyc), 160'(0));
        advance();
        sample();
        chk("h1_scyc_rise", 160'({grant, s_cyc, s_adr}), 160'({2'b01, 1'b1, 32'h0000_0100}));
        advance();
        sample();
        advance();
        s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
        sample();
        chk("h1_ack", 160'({m0_ack, m0_rdat, m1_ack, grant}),
            160'({1'b1, 32'hDEAD_BEEF, 1'b0, 2'b01}));
        advance();
        mc[0] = 1'b0; ms[0] = 1'b0; s_ack = 1'b0;
        sample();
        chk("h1_release", 160'({grant, m0_ack}), 160'(0));
        advance();

        // m1 write, acked on its first granted cycle
        mc[1] = 1'b1; ms[1] = 1'b1; mw[1] = 1'b1;
        ma[1] = 32'h8000_0004; mwd[1] = 32'h1234_5678; msl[1] = 4'b0011;
        sample();
        advance();
        s_ack = 1'b1;
        sample();
        chk("h2_write", 160'({s_we, s_sel, s_wdat, s_adr, m1_ack, m1_err}),
            160'({1'b1, 4'b0011, 32'h1234_5678, 32'h8000_0004, 1'b1, 1'b0}));
        advance();
        mc[1] = 1'b0; ms[1] = 1'b0; mw[1] = 1'b0; s_ack = 1'b0;
        sample();
        advance();

        // Reset in the middle of a granted m0 transaction, m0 keeps requesting
        mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 32'h0000_0200;
        sample();
        advance();
        sample();
        chk("h3_granted", 160'(grant), 160'(2'b01));
        advance();
        rst = 1'b1; s_ack = 1'b1;
        sample();
        chk("h3_rst_outputs", 160'({s_cyc, s_stb, m0_ack, m0_err}), 160'(0));
        advance();
        rst = 1'b0; s_ack = 1'b0;
        sample();
        chk("h3_after_rst", 160'({grant, s_cyc}), 160'(0));
        advance();
        sample();
        chk("h3_regrant", 160'({grant, s_cyc}), 160'({2'b01, 1'b1}));
        advance();
        s_ack = 1'b1;
        sample();
        advance();
        idle_masters();
        s_ack = 1'b0;
        sample();
        advance();

        // Randomized traffic from protocol-abiding masters against a random slave
        for (int n = 0; n < 3000; n++) begin
            for (int x = 0; x < 2; x++) begin
                done_x = (x == 0) ? (exp_o.a0 | exp_o.e0) : (exp_o.a1 | exp_o.e1);
                if (!mc[x]) begin
                    ms[x] = 1'b0;
                    if ($urandom_range(2) == 0) begin
                        mc[x] = 1'b1; ms[x] = 1'b1; mw[x] = 1'($urandom);
                        ma[x] = $urandom; msl[x] = 4'($urandom); mwd[x] = $urandom;
                    end
                end else if (done_x) begin
                    if ($urandom_range(3) == 0) begin
                        mw[x] = 1'($urandom); ma[x] = $urandom;
                        msl[x] = 4'($urandom); mwd[x] = $urandom;
                    end else begin
                        mc[x] = 1'b0; ms[x] = 1'b0;
                    end
                end else if ($urandom_range(39) == 0) begin
                    mc[x] = 1'b0; ms[x] = 1'($urandom);
                end
            end
            rst    = ($urandom_range(249) == 0);
            s_ack  = ($urandom_range(2) == 0);
            s_err  = ($urandom_range(15) == 0);
            s_rdat = $urandom;
            sample();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
